mem_arbiter: RTL and testbench

- Shares one single-port, multi-cycle memory between instruction fetch (IF) and the data-memory stage (DM).
- DM ops come from the decoder's mem_rd/mem_wr.
- Sequences each access (issue, wait, respond) and generates per-client done/stall.
- Enforces a fetch anti-starvation limit and HALT drain behaviour.

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/arb_pick.sv | 39 +++
 rtl/mem_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared encodings and default widths for mem_arbiter
package mem_arb_pkg;

  localparam int ADDR_W_DEF     = 16;
  localparam int DATA_W_DEF     = 16;
  localparam int STARVE_LIM_DEF = 3;
  localparam int STARVE_W       = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    WAIT   = 3'd2,
    RESP   = 3'd3,
    HALTED = 3'd4
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

endpackage

// File: rtl/arb_pick.sv
// rtl/arb_pick.sv - fetch/data winner selection with fetch anti-starvation counter
module arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIM = STARVE_LIM_DEF
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   idle,
  input  logic   en,
  input  logic   if_req,
  input  logic   dm_req,
  output logic   grant,
  output owner_e winner
);

  localparam logic [STARVE_W-1:0] LIM = STARVE_W'(STARVE_LIM);

  logic [STARVE_W-1:0] starve;

  always_comb begin
    grant  = en & (if_req | dm_req);
    winner = (if_req & (~dm_req | (starve == LIM))) ? OWN_IF : OWN_DM;
  end

  // Counts consecutive data grants that fetch lost; only arbitration cycles touch it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve <= '0;
    end else if (idle) begin
      if (!if_req || (grant && winner == OWN_IF)) begin
        starve <= '0;
      end else if (grant && starve != LIM) begin
        starve <= starve + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter between fetch and data stages
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_LIM = STARVE_LIM_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,
  input  logic              dm_rd,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_done,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_stall,
  input  logic              halt,
  output logic              halted,
  output logic              err,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_stall,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e        state, state_nxt;
  owner_e            own_q, winner;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              grant, dm_req, conflict, idle;

  assign dm_req   = dm_rd | dm_wr;
  assign conflict = dm_rd & dm_wr;
  assign idle     = (state == IDLE);

  arb_pick #(.STARVE_LIM(STARVE_LIM)) u_pick (
    .clk    (clk),
    .rst    (rst),
    .idle   (idle),
    .en     (idle & ~halt & ~conflict),
    .if_req (if_req),
    .dm_req (dm_req),
    .grant  (grant),
    .winner (winner)
  );

  always_comb begin
    state_nxt = state;
    mem_en    = 1'b0;
    halted    = 1'b0;
    unique case (state)
      IDLE: begin
        if (halt)       state_nxt = HALTED;
        else if (grant) state_nxt = ISSUE;
      end
      ISSUE: begin
        mem_en = 1'b1;
        if (!mem_stall) state_nxt = WAIT;
      end
      WAIT: begin
        if (mem_done) state_nxt = RESP;
      end
      RESP: begin
        state_nxt = halt ? HALTED : IDLE;
      end
      HALTED: begin
        halted = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      own_q    <= OWN_IF;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      if_done  <= 1'b0;
      dm_done  <= 1'b0;
      if_rdata <= '0;
      dm_rdata <= '0;
      err      <= 1'b0;
    end else begin
      state   <= state_nxt;
      if_done <= 1'b0;
      dm_done <= 1'b0;
      err     <= idle & ~halt & conflict;
      if (idle && grant) begin
        own_q   <= winner;
        wr_q    <= (winner == OWN_DM) & dm_wr;
        addr_q  <= (winner == OWN_DM) ? dm_addr : if_addr;
        wdata_q <= (winner == OWN_DM) ? dm_wdata : '0;
      end
      // Done pulses coincide with RESP; rdata registers hold until the owner's next response.
      if (state == WAIT && mem_done) begin
        if (own_q == OWN_IF) begin
          if_done  <= 1'b1;
          if_rdata <= mem_rdata;
        end else begin
          dm_done  <= 1'b1;
          dm_rdata <= wr_q ? '0 : mem_rdata;
        end
      end
    end
  end

  assign mem_wr    = wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_stall  = if_req & ~if_done & ~rst;
  assign dm_stall  = dm_req & ~dm_done & ~rst;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter
module tb_mem_arbiter;

  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int LIM = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_done, if_stall;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          dm_rd, dm_wr, dm_done, dm_stall;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata, dm_rdata;
  logic          halt, halted, err;
  logic          mem_en, mem_wr, mem_stall, mem_done;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIM(LIM)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata), .if_stall(if_stall),
    .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_done(dm_done), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
    .halt(halt), .halted(halted), .err(err),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_stall(mem_stall), .mem_done(mem_done), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle-time %0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: one access in flight at a time, tracked as a transaction record.
  bit          m_free, m_issue, m_wait, m_resp, m_halted, m_err, m_own, m_wr;
  logic [15:0] m_addr, m_wdata, m_if_hold, m_dm_hold;
  int          m_starve;

  // Stimulus knobs and client/memory bookkeeping.
  int p_if, p_dm, p_drop, p_stall, max_d, stall_burst;
  bit fixed, halt_req, force_done;
  bit if_pend, if_drop, dm_pend, dm_drop, armed;
  int dcnt, cyc, if_req_cyc, if_done_cyc, en_first_cyc, en_run, last_run, acc_cnt, err_cnt;
  bit own_log[$];

  task automatic check_zero(input string tag);
    check({tag, "_mem_en"},   mem_en, 0);
    check({tag, "_mem_wr"},   mem_wr, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wd"},   mem_wdata, 0);
    check({tag, "_if_done"},  if_done, 0);
    check({tag, "_dm_done"},  dm_done, 0);
    check({tag, "_if_rdata"}, if_rdata, 0);
    check({tag, "_dm_rdata"}, dm_rdata, 0);
    check({tag, "_err"},      err, 0);
    check({tag, "_halted"},   halted, 0);
    check({tag, "_if_stall"}, if_stall, 0);
    check({tag, "_dm_stall"}, dm_stall, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    if_req = 0; if_addr = 0; dm_rd = 0; dm_wr = 0; dm_addr = 0; dm_wdata = 0;
    halt = 0; halt_req = 0; mem_stall = 0; mem_done = 0; mem_rdata = 0;
    if_pend = 0; if_drop = 0; dm_pend = 0; dm_drop = 0; armed = 0; force_done = 0;
    stall_burst = 0; en_run = 0;
    m_free = 1; m_issue = 0; m_wait = 0; m_resp = 0; m_halted = 0; m_err = 0;
    m_own = 0; m_wr = 0; m_addr = 0; m_wdata = 0; m_starve = 0; m_if_hold = 0; m_dm_hold = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step();
    int r;
    @(negedge clk);
    cyc++;
    if (if_done) begin if_pend = 0; if_drop = 0; if_done_cyc = cyc; end
    if (dm_done) begin dm_pend = 0; dm_drop = 0; dm_rd = 0; dm_wr = 0; end
    if (err) begin dm_wr = 0; err_cnt++; end

    if (!if_pend && !if_drop && $urandom_range(99) < p_if) begin
      if_pend = 1; if_req_cyc = cyc;
      if_addr = fixed ? 16'h0010 : 16'($urandom);
    end else if (if_pend && !m_free && !m_halted && !m_own && $urandom_range(99) < p_drop) begin
      if_pend = 0; if_drop = 1;
    end
    if_req = if_pend;

    if (!dm_pend && !dm_drop && $urandom_range(99) < p_dm) begin
      dm_pend  = 1;
      dm_addr  = fixed ? 16'h0200 : 16'($urandom);
      dm_wdata = fixed ? 16'h1234 : 16'($urandom);
      r = fixed ? 8 : $urandom_range(15);
      dm_rd = (r < 8) || (r == 15);
      dm_wr = (r >= 8);
    end else if (dm_pend && !m_free && !m_halted && m_own && $urandom_range(99) < p_drop) begin
      dm_pend = 0; dm_drop = 1; dm_rd = 0; dm_wr = 0;
    end
    halt = halt_req;

    mem_done = 0;
    if (force_done) begin
      mem_done = 1; force_done = 0;
    end else if (armed) begin
      if (dcnt == 0) begin mem_done = 1; armed = 0; end
      else dcnt--;
    end
    mem_rdata = fixed ? 16'hBEEF : 16'($urandom);
    if (mem_en && stall_burst > 0) begin
      mem_stall = 1; stall_burst--;
    end else begin
      mem_stall = ($urandom_range(99) < p_stall);
    end
    if (mem_en) begin
      en_run++;
      if (en_run == 1) en_first_cyc = cyc;
    end else begin
      en_run = 0;
    end
    if (mem_en && !mem_stall) begin
      armed = 1; dcnt = $urandom_range(max_d); acc_cnt++; last_run = en_run; en_run = 0;
      own_log.push_back(mem_addr == 16'h0200);
    end
    #1;

    check("mem_en", mem_en, m_issue);
    if (m_issue) begin
      check("mem_addr", mem_addr, m_addr);
      check("mem_wr", mem_wr, m_wr);
      if (m_wr) check("mem_wdata", mem_wdata, m_wdata);
    end
    check("if_done", if_done, m_resp && !m_own);
    check("dm_done", dm_done, m_resp && m_own);
    check("if_rdata", if_rdata, m_if_hold);
    check("dm_rdata", dm_rdata, m_dm_hold);
    check("err", err, m_err);
    check("halted", halted, m_halted);
    check("if_stall", if_stall, if_req && !(m_resp && !m_own));
    check("dm_stall", dm_stall, (dm_rd || dm_wr) && !(m_resp && m_own));

    m_err = 0;
    if (m_halted) begin
      m_halted = 1;
    end else if (m_free) begin
      if (!if_req) m_starve = 0;
      if (halt) begin
        m_free = 0; m_halted = 1;
      end else if (dm_rd && dm_wr) begin
        m_err = 1;
      end else if (if_req || dm_rd || dm_wr) begin
        if (if_req && (!(dm_rd || dm_wr) || m_starve == LIM)) begin
          m_own = 0; m_addr = if_addr; m_wr = 0; m_wdata = 0; m_starve = 0;
        end else begin
          m_own = 1; m_addr = dm_addr; m_wr = dm_wr; m_wdata = dm_wdata;
          if (if_req) m_starve = (m_starve < LIM) ? m_starve + 1 : LIM;
        end
        m_free = 0; m_issue = 1;
      end
    end else if (m_issue) begin
      if (!mem_stall) begin m_issue = 0; m_wait = 1; end
    end else if (m_wait) begin
      if (mem_done) begin
        m_wait = 0; m_resp = 1;
        if (!m_own) m_if_hold = mem_rdata;
        else        m_dm_hold = m_wr ? 16'h0 : mem_rdata;
      end
    end else if (m_resp) begin
      m_resp = 0;
      if (halt) m_halted = 1;
      else      m_free = 1;
    end
  endtask

  task automatic knobs(input int pi, input int pd, input int pdr, input int ps, input int md, input bit fx);
    p_if = pi; p_dm = pd; p_drop = pdr; p_stall = ps; max_d = md; fixed = fx;
  endtask

  initial begin
    logic [4:0] pat;
    int acc0;
    cyc = 0; acc_cnt = 0; err_cnt = 0; if_done_cyc = 0; en_first_cyc = 0; last_run = 0;
    knobs(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    if_req = 0; if_addr = 0; dm_rd = 0; dm_wr = 0; dm_addr = 0; dm_wdata = 0;
    halt = 0; mem_stall = 0; mem_done = 0; mem_rdata = 0;
    #3;
    check_zero("reset");
    do_reset();

    // Random mixed traffic with stalls, variable memory latency and dropped requests.
    knobs(40, 40, 3, 30, 3, 0);
    repeat (3000) step();
    check("err_seen", err_cnt > 0, 1);

    // Continuous contention from a clean starve count.
    do_reset();
    knobs(100, 100, 0, 0, 1, 1);
    own_log.delete();
    repeat (40) step();
    pat = 5'b10111;
    for (int i = 0; i < 5; i++)
      check($sformatf("grant_order_%0d", i), (i < own_log.size()) ? 32'(own_log[i]) : 32'd2, 32'(pat[i]));

    // Asynchronous reset in the middle of WAIT, then a stray mem_done.
    do_reset();
    knobs(40, 40, 0, 0, 3, 0);
    for (int i = 0; i < 200 && !m_wait; i++) step();
    check("reach_wait", m_wait, 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_zero("rst_async");
    do_reset();
    knobs(0, 0, 0, 0, 0, 0);
    force_done = 1;
    repeat (6) step();

    // Fetch-only latency: mem_en one cycle after the request, done three cycles after.
    knobs(100, 0, 0, 0, 0, 1);
    if_done_cyc = 0;
    step();
    p_if = 0;
    for (int i = 0; i < 20 && if_done_cyc == 0; i++) step();
    check("if_mem_en_lat", en_first_cyc - if_req_cyc, 1);
    check("if_done_lat", if_done_cyc - if_req_cyc, 3);
    step();
    check("if_rdata_beef", if_rdata, 16'hBEEF);

    // Five stalled cycles in ISSUE keep the strobe up for six cycles, one access only.
    acc0 = acc_cnt;
    stall_burst = 5;
    if_done_cyc = 0;
    p_if = 100;
    step();
    p_if = 0;
    for (int i = 0; i < 40 && if_done_cyc == 0; i++) step();
    check("stall_run", last_run, 6);
    check("stall_single_acc", acc_cnt - acc0, 1);

    // Halt raised while a data read waits on memory.
    knobs(40, 60, 0, 20, 3, 0);
    for (int i = 0; i < 1000 && !(m_wait && m_own && !m_wr); i++) step();
    check("reach_dm_rd_wait", m_wait && m_own && !m_wr, 1);
    halt_req = 1;
    for (int i = 0; i < 40 && !halted; i++) step();
    check("halted_reached", halted, 1);
    acc0 = acc_cnt;
    knobs(100, 0, 0, 0, 0, 0);
    repeat (30) step();
    check("halted_no_access", acc_cnt - acc0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
